// File: rtl/rsdp_tag_seq.sv
// rsdp_tag_seq: load/run/done sequencer for the RSDP tag inner-product datapath.
// Optional build macro TAG_AUTO_CHAIN_EN: one start runs b/y then a/x back to back.
module rsdp_tag_seq #(
    parameter int N_ELEM = 34,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pair_sel,
    input  logic init_e,
    output logic ldb,
    output logic lda,
    output logic ldy,
    output logic ldx,
    output logic lde,
    output logic innerprod,
    output logic busy,
    output logic done
);
`ifdef TAG_AUTO_CHAIN_EN
    typedef enum logic [2:0] {IDLE, LOAD, RUN, LOAD2, RUN2, DONE} state_t;
    logic unused_pair_sel;
    assign unused_pair_sel = pair_sel;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
`endif
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_ELEM - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sel_q, sel_d, init_q, init_d;
    logic ldb_q, ldb_d, lda_q, lda_d, ldy_q, ldy_d, ldx_q, ldx_d;
    logic lde_q, lde_d, innerprod_q, innerprod_d, busy_q, busy_d, done_q, done_d;
    // State, counter, captured request and registered (Moore) outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            init_q      <= 1'b0;
            ldb_q       <= 1'b0;
            lda_q       <= 1'b0;
            ldy_q       <= 1'b0;
            ldx_q       <= 1'b0;
            lde_q       <= 1'b0;
            innerprod_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            init_q      <= init_d;
            ldb_q       <= ldb_d;
            lda_q       <= lda_d;
            ldy_q       <= ldy_d;
            ldx_q       <= ldx_d;
            lde_q       <= lde_d;
            innerprod_q <= innerprod_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
    // Next state; a run leaves only when the down-counter reaches zero, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        init_d  = init_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d   = CNT_INIT;
`ifdef TAG_AUTO_CHAIN_EN
                sel_d   = 1'b0;
`else
                sel_d   = pair_sel;
`endif
                init_d  = init_e;
            end
            LOAD: state_d = RUN;
`ifdef TAG_AUTO_CHAIN_EN
            RUN: if (cnt_q == '0) begin
                state_d = LOAD2;
                cnt_d   = CNT_INIT;
            end else cnt_d = cnt_q - CNT_W'(1);
            LOAD2: state_d = RUN2;
            RUN2: if (cnt_q == '0) state_d = DONE;
                  else cnt_d = cnt_q - CNT_W'(1);
`else
            RUN: if (cnt_q == '0) state_d = DONE;
                 else cnt_d = cnt_q - CNT_W'(1);
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are decoded from the upcoming state so they appear registered in that state.
    always_comb begin
        ldb_d       = state_d == LOAD && !sel_d;
        lda_d       = state_d == LOAD && sel_d;
        lde_d       = state_d == LOAD && init_d;
        innerprod_d = state_d == RUN;
`ifdef TAG_AUTO_CHAIN_EN
        lda_d       = lda_d || state_d == LOAD2;
        innerprod_d = innerprod_d || state_d == RUN2;
`endif
        ldy_d       = ldb_d;
        ldx_d       = lda_d;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end
    assign ldb       = ldb_q;
    assign lda       = lda_q;
    assign ldy       = ldy_q;
    assign ldx       = ldx_q;
    assign lde       = lde_q;
    assign innerprod = innerprod_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_rsdp_tag_seq.sv
// tb_rsdp_tag_seq: randomized scoreboard bench for rsdp_tag_seq.
module tb_rsdp_tag_seq;
    localparam int N = 34;
`ifdef TAG_AUTO_CHAIN_EN
    localparam int DONE_PH = 2 * N + 2;
`else
    localparam int DONE_PH = N + 1;
`endif
    typedef struct {
        int   e;
        logic p;
        logic i;
    } txn_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pair_sel = 1'b0, init_e = 1'b0;
    logic ldb, lda, ldy, ldx, lde, innerprod, busy, done;
    txn_t q[$];
    int edge_n = 0, n_chk = 0, n_pass = 0, n_done = 0;
    bit mon_en = 1'b0;
    rsdp_tag_seq #(.N_ELEM(N), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .pair_sel(pair_sel), .init_e(init_e),
        .ldb(ldb), .lda(lda), .ldy(ldy), .ldx(ldx), .lde(lde),
        .innerprod(innerprod), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // Expected {ldb,lda,ldy,ldx,lde,innerprod,busy,done} at phase ph after the accepting edge.
    function automatic logic [7:0] exp_out(int ph, logic p, logic i);
        if (ph == 0) return {~p, p, ~p, p, i, 3'b010};
`ifdef TAG_AUTO_CHAIN_EN
        if (ph == N + 1) return 8'b01010010;
        if ((ph >= 1 && ph <= N) || (ph >= N + 2 && ph <= 2 * N + 1)) return 8'b00000110;
`else
        if (ph >= 1 && ph <= N) return 8'b00000110;
`endif
        if (ph == DONE_PH) return 8'b00000011;
        return 8'b0;
    endfunction
    task automatic step(input logic r, input logic s, input logic p, input logic i);
        @(negedge clk);
        rst = r; start = s; pair_sel = p; init_e = i;
        @(posedge clk);
        edge_n++;
        if (r) q.delete();
        else if (s && (q.size() == 0 || edge_n >= q[$].e + DONE_PH + 2)) begin
`ifdef TAG_AUTO_CHAIN_EN
            q.push_back('{edge_n, 1'b0, i});
`else
            q.push_back('{edge_n, p, i});
`endif
        end
    endtask
    always @(negedge clk) begin
        logic [7:0] ex, got;
        if (mon_en) begin
            while (q.size() > 0 && edge_n - q[0].e > DONE_PH) void'(q.pop_front());
            ex  = q.size() > 0 ? exp_out(edge_n - q[0].e, q[0].p, q[0].i) : 8'b0;
            got = {ldb, lda, ldy, ldx, lde, innerprod, busy, done};
            if (done) n_done++;
            n_chk++;
            if (got === ex) n_pass++;
            else $display("FAIL outputs cycle %0d: got %b expected %b", edge_n, got, ex);
        end
    end
    initial begin
        int dones0;
        step(1, 0, 0, 0);
        mon_en = 1'b1;
        step(1, 1, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        dones0 = n_done;
        step(0, 1, 0, 1);
        for (int k = 1; k < DONE_PH + 4; k++) step(0, 0, $urandom_range(1), $urandom_range(1));
        step(0, 1, 1, 0);
        for (int k = 1; k < DONE_PH + 4; k++)
            step(0, k == 10 || k == 30, k % 2 == 0, k % 3 == 0);
        n_chk++;
        if (n_done - dones0 == 2) n_pass++;
        else $display("FAIL done_count: got %0d expected 2", n_done - dones0);
        step(0, 1, 0, 1);
        for (int k = 1; k < 11; k++) step(0, 0, 0, 0);
        dones0 = n_done;
        step(1, 0, 0, 0);
        repeat (DONE_PH + 2) step(0, 0, 0, 0);
        n_chk++;
        if (n_done == dones0) n_pass++;
        else $display("FAIL abort_no_done: got %0d expected %0d", n_done, dones0);
        step(0, 1, 1, 1);
        repeat (DONE_PH + 3) step(0, 0, 0, 0);
        for (int k = 0; k < 4000; k++)
            step($urandom_range(299) == 0, $urandom_range(3) == 0, $urandom_range(1), $urandom_range(1));
        repeat (DONE_PH + 3) step(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
